count_stream_monitor: RTL and testbench



---
 rtl/count_stream_monitor_if.sv | 9 +
 rtl/count_stream_monitor.sv | 162 ++++++++++++++++
 tb/tb_count_stream_monitor.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/count_stream_monitor_if.sv
// Sample stream carrying the observed counter bus into the monitor.
// Valid-only stream: there is no ready, so the monitor takes every beat with sample_valid high.
interface count_stream_monitor_if;
    logic       sample_valid;
    logic [7:0] count_in;

    modport master (output sample_valid, output count_in);
    modport slave  (input  sample_valid, input  count_in);
endinterface

// File: rtl/count_stream_monitor.sv
// Decodes successive samples of an 8-bit up/down counter bus into hold/step/jump events,
// with saturating event statistics and a signed net-displacement accumulator.
module count_stream_monitor #(
    parameter int CNT_W       = 16,
    parameter int POS_W       = 16,
    parameter int STALL_LIMIT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    count_stream_monitor_if.slave  stream_i,
    output logic                   tracking,
    output logic                   step_up,
    output logic                   step_down,
    output logic                   jump,
    output logic                   wrap,
    output logic                   last_dir,
    output logic                   stalled,
    output logic [CNT_W-1:0]       up_count,
    output logic [CNT_W-1:0]       down_count,
    output logic [CNT_W-1:0]       jump_count,
    output logic [POS_W-1:0]       position,
    output logic                   fsm_state_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    localparam int               RUN_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [7:0]       prev_q, prev_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             stalled_q, stalled_d;
    logic             step_up_q, step_up_d;
    logic             step_down_q, step_down_d;
    logic             jump_q, jump_d;
    logic             wrap_q, wrap_d;
    logic             last_dir_q, last_dir_d;
    logic [CNT_W-1:0] up_q, up_d;
    logic [CNT_W-1:0] down_q, down_d;
    logic [CNT_W-1:0] jump_cnt_q, jump_cnt_d;
    logic [POS_W-1:0] pos_q, pos_d;

    logic [7:0]       delta;
    logic [POS_W-1:0] delta_sx;

    assign delta    = stream_i.count_in - prev_q;
    assign delta_sx = POS_W'($signed(delta));

    // State register: rst and clear both return everything to the idle, all-zero state.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            run_q       <= '0;
            stalled_q   <= 1'b0;
            step_up_q   <= 1'b0;
            step_down_q <= 1'b0;
            jump_q      <= 1'b0;
            wrap_q      <= 1'b0;
            last_dir_q  <= 1'b0;
            up_q        <= '0;
            down_q      <= '0;
            jump_cnt_q  <= '0;
            pos_q       <= '0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            stalled_q   <= stalled_d;
            step_up_q   <= step_up_d;
            step_down_q <= step_down_d;
            jump_q      <= jump_d;
            wrap_q      <= wrap_d;
            last_dir_q  <= last_dir_d;
            up_q        <= up_d;
            down_q      <= down_d;
            jump_cnt_q  <= jump_cnt_d;
            pos_q       <= pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (stream_i.sample_valid) begin
            state_d = ST_TRACK;
        end
    end

    // Event decode: the first sample after idle is only a reference, later ones are classified.
    always_comb begin
        prev_d      = prev_q;
        run_d       = run_q;
        stalled_d   = stalled_q;
        step_up_d   = 1'b0;
        step_down_d = 1'b0;
        jump_d      = 1'b0;
        wrap_d      = 1'b0;
        last_dir_d  = last_dir_q;
        up_d        = up_q;
        down_d      = down_q;
        jump_cnt_d  = jump_cnt_q;
        pos_d       = pos_q;

        if (stream_i.sample_valid) begin
            prev_d = stream_i.count_in;
            if (state_q == ST_TRACK) begin
                if (delta == 8'h00) begin
                    if (run_q != RUN_MAX) begin
                        run_d = run_q + RUN_W'(1);
                    end
                    stalled_d = (run_d == RUN_MAX);
                end else begin
                    run_d     = '0;
                    stalled_d = 1'b0;
                    if (delta == 8'h01) begin
                        step_up_d  = 1'b1;
                        wrap_d     = (prev_q == 8'hFF);
                        last_dir_d = 1'b1;
                        pos_d      = pos_q + POS_W'(1);
                        if (up_q != CNT_MAX) begin
                            up_d = up_q + CNT_W'(1);
                        end
                    end else if (delta == 8'hFF) begin
                        step_down_d = 1'b1;
                        wrap_d      = (prev_q == 8'h00);
                        last_dir_d  = 1'b0;
                        pos_d       = pos_q - POS_W'(1);
                        if (down_q != CNT_MAX) begin
                            down_d = down_q + CNT_W'(1);
                        end
                    end else begin
                        jump_d = 1'b1;
                        pos_d  = pos_q + delta_sx;
                        if (jump_cnt_q != CNT_MAX) begin
                            jump_cnt_d = jump_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign tracking    = (state_q == ST_TRACK);
    assign fsm_state_o = state_q;
    assign step_up     = step_up_q;
    assign step_down   = step_down_q;
    assign jump        = jump_q;
    assign wrap        = wrap_q;
    assign last_dir    = last_dir_q;
    assign stalled     = stalled_q;
    assign up_count    = up_q;
    assign down_count  = down_q;
    assign jump_count  = jump_cnt_q;
    assign position    = pos_q;

endmodule

// File: tb/tb_count_stream_monitor.sv
// Self-checking bench for count_stream_monitor: directed scenarios plus random traffic,
// checked every cycle against an arithmetic model of the event rules.
module tb_count_stream_monitor;

    localparam int CNT_W       = 16;
    localparam int POS_W       = 16;
    localparam int STALL_LIMIT = 16;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             clear;
    logic             tracking, step_up, step_down, jump, wrap, last_dir, stalled;
    logic [CNT_W-1:0] up_count, down_count, jump_count;
    logic [POS_W-1:0] position;
    logic             fsm_state;

    count_stream_monitor_if cs ();

    count_stream_monitor #(
        .CNT_W(CNT_W), .POS_W(POS_W), .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .stream_i(cs),
        .tracking(tracking), .step_up(step_up), .step_down(step_down), .jump(jump),
        .wrap(wrap), .last_dir(last_dir), .stalled(stalled),
        .up_count(up_count), .down_count(down_count), .jump_count(jump_count),
        .position(position), .fsm_state_o(fsm_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the classification rules
    bit m_track, m_up_p, m_dn_p, m_jmp_p, m_wrap_p, m_dir, m_stall;
    int m_prev, m_run, m_up, m_down, m_jump, m_pos;

    always @(posedge clk) begin
        int d, sd;
        m_up_p = 0; m_dn_p = 0; m_jmp_p = 0; m_wrap_p = 0;
        if (rst || clear) begin
            m_track = 0; m_dir = 0; m_stall = 0; m_prev = 0; m_run = 0;
            m_up = 0; m_down = 0; m_jump = 0; m_pos = 0;
        end else if (cs.sample_valid) begin
            if (!m_track) begin
                m_track = 1;
            end else begin
                d  = (int'(cs.count_in) - m_prev + 256) % 256;
                sd = (d >= 128) ? d - 256 : d;
                if (d == 0) begin
                    if (m_run < STALL_LIMIT) m_run++;
                    m_stall = (m_run >= STALL_LIMIT);
                end else begin
                    m_run = 0; m_stall = 0;
                    if (d == 1) begin
                        m_up_p = 1; m_dir = 1; m_pos += 1;
                        m_wrap_p = (m_prev == 255);
                        if (m_up < CNT_MAX) m_up++;
                    end else if (d == 255) begin
                        m_dn_p = 1; m_dir = 0; m_pos -= 1;
                        m_wrap_p = (m_prev == 0);
                        if (m_down < CNT_MAX) m_down++;
                    end else begin
                        m_jmp_p = 1; m_pos += sd;
                        if (m_jump < CNT_MAX) m_jump++;
                    end
                end
            end
            m_prev = int'(cs.count_in);
        end
    end

    // Scoreboard compare on the falling edge, away from the sampling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tracking",   32'(tracking),   32'(m_track));
            chk("step_up",    32'(step_up),    32'(m_up_p));
            chk("step_down",  32'(step_down),  32'(m_dn_p));
            chk("jump",       32'(jump),       32'(m_jmp_p));
            chk("wrap",       32'(wrap),       32'(m_wrap_p));
            chk("last_dir",   32'(last_dir),   32'(m_dir));
            chk("stalled",    32'(stalled),    32'(m_stall));
            chk("up_count",   32'(up_count),   32'(m_up));
            chk("down_count", 32'(down_count), 32'(m_down));
            chk("jump_count", 32'(jump_count), 32'(m_jump));
            chk("position",   32'(position),   32'(m_pos) & 32'hFFFF);
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge
    logic [7:0] last_v;

    task automatic send(input logic [7:0] v);
        cs.sample_valid = 1'b1;
        cs.count_in     = v;
        last_v          = v;
        @(posedge clk); #1;
        cs.sample_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0;
        cs.sample_valid = 1'b0; cs.count_in = 8'h00; last_v = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset_tracking", 32'(tracking), 32'd0);
        chk("reset_position", 32'(position), 32'd0);
        rst = 1'b0;

        // Counting up from 0x10
        send(8'h10); send(8'h11); send(8'h12);
        chk("t1_up_count", 32'(up_count), 32'd2);
        chk("t1_position", 32'(position), 32'd2);
        chk("t1_last_dir", 32'(last_dir), 32'd1);
        chk("t1_step_up",  32'(step_up),  32'd1);
        chk("t1_tracking", 32'(tracking), 32'd1);
        idle_cycle();
        chk("t1_idle_no_pulse", 32'(step_up), 32'd0);

        // Wrap in both directions
        pulse_clear();
        send(8'hFE); send(8'hFF);
        send(8'h00);
        chk("t2_wrap_up", 32'({step_up, wrap}), 32'b11);
        send(8'hFF);
        chk("t2_wrap_dn",    32'({step_down, wrap}), 32'b11);
        chk("t2_up_count",   32'(up_count),   32'd2);
        chk("t2_down_count", 32'(down_count), 32'd1);
        chk("t2_position",   32'(position),   32'd1);
        chk("t2_last_dir",   32'(last_dir),   32'd0);

        // Jumps with signed deltas
        pulse_clear();
        send(8'h20); send(8'h90);
        chk("t3_jump",       32'(jump),       32'd1);
        chk("t3_jump_count", 32'(jump_count), 32'd1);
        chk("t3_pos_plus",   32'(position),   32'h0070);
        send(8'h10);
        chk("t3_pos_minus",  32'(position),   32'hFFF0);
        chk("t3_jump_cnt2",  32'(jump_count), 32'd2);

        // Stall detection at exactly STALL_LIMIT holds
        pulse_clear();
        repeat (16) send(8'h05);
        chk("t4_not_stalled", 32'(stalled), 32'd0);
        send(8'h05);
        chk("t4_stalled", 32'(stalled), 32'd1);
        idle_cycle();
        chk("t4_stall_holds", 32'(stalled), 32'd1);
        send(8'h06);
        chk("t4_unstall", 32'({stalled, step_up}), 32'b01);

        // clear coincident with a valid sample discards it
        pulse_clear();
        send(8'h30); send(8'h31);
        clear = 1'b1; cs.sample_valid = 1'b1; cs.count_in = 8'h32;
        @(posedge clk); #1;
        clear = 1'b0; cs.sample_valid = 1'b0;
        chk("t5_tracking", 32'(tracking), 32'd0);
        chk("t5_up_count", 32'(up_count), 32'd0);
        send(8'h40);
        chk("t5_ref_only", 32'({step_up, step_down, jump}), 32'd0);
        send(8'h41);
        chk("t5_step_up",  32'(step_up),  32'd1);
        chk("t5_position", 32'(position), 32'd1);

        // Random traffic biased toward holds and single steps
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                pulse_clear();
            end else if (r < 4) begin
                rst = 1'b1; idle_cycle(); rst = 1'b0;
            end else if (r < 25) begin
                idle_cycle();
            end else begin
                case ($urandom_range(0, 3))
                    0: send(last_v);
                    1: send(last_v + 8'd1);
                    2: send(last_v - 8'd1);
                    default: send(8'($urandom_range(0, 255)));
                endcase
            end
        end

        // Saturation of up_count while position keeps wrapping
        pulse_clear();
        send(8'h00);
        for (int i = 1; i <= CNT_MAX; i++) begin
            send(8'(i));
        end
        chk("t6_up_max",  32'(up_count), 32'hFFFF);
        chk("t6_pos_max", 32'(position), 32'hFFFF);
        send(8'h00);
        chk("t6_up_sat",   32'(up_count), 32'hFFFF);
        chk("t6_pos_wrap", 32'(position), 32'h0000);
        chk("t6_step_wrap", 32'({step_up, wrap}), 32'b11);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
